// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int unsigned UART_DATA_BITS = 8;

   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; the head entry is presented on rd_data
// whenever the FIFO is not empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_wr, do_rd;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_comb begin
      count_d = count_q;
      unique case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small input FIFO; frames go out back-to-back while
// the FIFO holds data.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 12_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          UART_TX,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, >= 2");
   end

   uart_state_t state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          pop, full, empty, bit_end;
   logic [7:0]    rd_data;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (tx_data),
      .wr_en   (tx_valid),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   assign tx_ready = !full;
   assign UART_TX  = tx_q;
   assign busy     = (state_q != IDLE) || !empty;
   assign bit_end  = (baud_q == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = rd_data;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            // Chain straight into the next start bit so a stream has no idle gap.
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = rd_data;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue/timestamp line model.
module tb_uart_tx_fifo;

   localparam int unsigned CLK_HZ = 12_000_000;
   localparam int unsigned BAUD   = 750_000;
   localparam int          CPB    = 16;
   localparam int          DEPTH  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, UART_TX, busy;
   logic [2:0] fifo_count;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference model: queue of pending bytes plus the frame currently on the line.
   logic [7:0] mq[$];
   logic [7:0] acc_q[$];
   logic [7:0] rx_q[$];
   bit         m_active = 0;
   int         m_start = 0;
   logic [7:0] m_byte = '0;

   uart_tx_fifo #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .UART_TX    (UART_TX),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #42 clk = ~clk;

   wire [5:0] dut_vec = {UART_TX, tx_ready, busy, fifo_count};

   function automatic logic [5:0] model_vec();
      logic ln;
      int   k;
      ln = 1'b1;
      if (m_active) begin
         k = (cyc - m_start) / CPB;
         if (k == 0) ln = 1'b0;
         else if (k <= 8) ln = m_byte[k-1];
      end
      return {ln, logic'(mq.size() != DEPTH), logic'(m_active || mq.size() != 0),
              3'(mq.size())};
   endfunction

   // Advance one clock edge and apply the same edge to the model.
   task automatic step();
      bit rdy, fend;
      @(posedge clk);
      cyc++;
      if (rst) begin
         mq.delete();
         m_active = 0;
      end else begin
         rdy  = (mq.size() != DEPTH);
         fend = m_active && (cyc - m_start == 10 * CPB);
         if ((!m_active || fend) && mq.size() != 0) begin
            m_byte   = mq.pop_front();
            m_start  = cyc;
            m_active = 1;
         end else if (fend) begin
            m_active = 0;
         end
         if (tx_valid && rdy) begin
            mq.push_back(tx_data);
            acc_q.push_back(tx_data);
         end
      end
      #1;
   endtask

   // Independent line decoder: mid-bit sampling after each falling edge.
   initial begin
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && UART_TX === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            if (UART_TX === 1'b0) begin
               for (int j = 0; j < 8; j++) begin
                  repeat (CPB) @(negedge clk);
                  b[j] = UART_TX;
               end
               repeat (CPB) @(negedge clk);
               if (UART_TX === 1'b1) rx_q.push_back(b);
            end
         end
         prev = UART_TX;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      tx_valid = 1'b0;
      repeat (5) step();
      rst = 1'b0;
      n_cmp++;
      if (UART_TX !== 1'b1) begin
         n_fail++; $display("FAIL reset_line got=%b exp=1", UART_TX);
      end
      n_cmp++;
      if (tx_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got=%b exp=1", tx_ready);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got=%b exp=0", busy);
      end
      n_cmp++;
      if (fifo_count !== 3'd0) begin
         n_fail++; $display("FAIL reset_count got=%0d exp=0", fifo_count);
      end
      for (int i = 0; i < 20 * CPB; i++) begin
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_single();
      int push_edge;
      rx_q.delete();
      tx_data = 8'h42;
      tx_valid = 1'b1;
      step();
      push_edge = cyc;
      tx_valid = 1'b0;
      step();
      n_cmp++;
      if (UART_TX !== 1'b0) begin
         n_fail++; $display("FAIL start_latency got=%b exp=0", UART_TX);
      end
      for (int i = 0; i < 10 * CPB + 4; i++) begin
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
         if (cyc == push_edge + 10 * CPB) begin
            n_cmp++;
            if (busy !== 1'b1) begin
               n_fail++; $display("FAIL busy_hold got=%b exp=1", busy);
            end
         end
         if (cyc == push_edge + 10 * CPB + 1) begin
            n_cmp++;
            if (busy !== 1'b0) begin
               n_fail++; $display("FAIL busy_fall got=%b exp=0", busy);
            end
         end
      end
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h42) begin
         n_fail++; $display("FAIL single_decode got_n=%0d exp=1 byte 42", rx_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int nxt, push1, acc6, max_cnt, idle_edge;
      bit acc;
      nxt = 1; push1 = -1; acc6 = -1; max_cnt = 0; idle_edge = -1;
      rx_q.delete();
      tx_valid = 1'b1;
      tx_data = 8'(nxt);
      for (int i = 0; i < 70 * CPB && idle_edge < 0; i++) begin
         acc = tx_valid && (mq.size() != DEPTH);
         step();
         if (acc) begin
            if (nxt == 1) push1 = cyc;
            if (nxt == 6) acc6 = cyc;
            nxt++;
            if (nxt > 6) tx_valid = 1'b0;
            else tx_data = 8'(nxt);
         end
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
         if (nxt > 6 && busy === 1'b0) idle_edge = cyc;
      end
      n_cmp++;
      if (max_cnt !== DEPTH) begin
         n_fail++; $display("FAIL max_count got=%0d exp=%0d", max_cnt, DEPTH);
      end
      n_cmp++;
      if (acc6 !== push1 + 2 + 10 * CPB) begin
         n_fail++; $display("FAIL byte6_accept got=%0d exp=%0d", acc6, push1 + 2 + 10 * CPB);
      end
      n_cmp++;
      if (idle_edge !== push1 + 1 + 60 * CPB) begin
         n_fail++;
         $display("FAIL stream_end got=%0d exp=%0d", idle_edge, push1 + 1 + 60 * CPB);
      end
      n_cmp++;
      if (rx_q.size() != 6) begin
         n_fail++; $display("FAIL stream_decode_n got=%0d exp=6", rx_q.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (rx_q[k] !== 8'(k + 1)) begin
               n_fail++; $display("FAIL stream_byte%0d got=%h exp=%h", k, rx_q[k], 8'(k + 1));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int start;
      tx_valid = 1'b1;
      tx_data = 8'hA5;
      step();
      start = cyc + 1;
      tx_data = 8'h3C;
      step();
      tx_valid = 1'b0;
      while (cyc < start + 4 * CPB + 3) begin
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL pre_rst cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if (UART_TX !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_line got=%b exp=1", UART_TX);
      end
      n_cmp++;
      if (fifo_count !== 3'd0) begin
         n_fail++; $display("FAIL rst_mid_count got=%0d exp=0", fifo_count);
      end
      for (int i = 0; i < 12 * CPB; i++) begin
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL post_rst cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
      end
      rx_q.delete();
      tx_valid = 1'b1;
      tx_data = 8'hA5;
      step();
      tx_valid = 1'b0;
      for (int i = 0; i < 11 * CPB; i++) begin
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL refr cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
      end
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         n_fail++; $display("FAIL rst_refr_decode got_n=%0d exp=1 byte a5", rx_q.size());
      end
   endtask

   task automatic test_random();
      bit acc;
      rx_q.delete();
      acc_q.delete();
      tx_valid = 1'b0;
      for (int i = 0; i < 80 * CPB; i++) begin
         if (!tx_valid && $urandom_range(0, 7) == 0) begin
            tx_valid = 1'b1;
            tx_data = 8'($urandom);
         end
         acc = tx_valid && (mq.size() != DEPTH);
         step();
         if (acc) tx_valid = 1'b0;
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL rand cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
      end
      tx_valid = 1'b0;
      for (int i = 0; i < 60 * CPB && (m_active || mq.size() != 0); i++) begin
         step();
         n_cmp++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
         end
      end
      repeat (2 * CPB) step();
      n_cmp++;
      if (rx_q.size() != acc_q.size()) begin
         n_fail++; $display("FAIL rand_decode_n got=%0d exp=%0d", rx_q.size(), acc_q.size());
      end else begin
         for (int k = 0; k < acc_q.size(); k++) begin
            n_cmp++;
            if (rx_q[k] !== acc_q[k]) begin
               n_fail++; $display("FAIL rand_byte%0d got=%h exp=%h", k, rx_q[k], acc_q[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
